amber128_mem_stage: RTL and testbench

Memory stage of the amber128 pipeline, directly downstream of the execute ALU. It consumes the `amber128_exec_out_s` record each cycle and passes non-memory results to writeback with one registered cycle of latency. It turns 128-bit LD/ST records into a valid/ready DMEM request and waits for the DMEM response. It then produces a single registered writeback/trap record, stalls execute while a memory op is in flight, and absorbs pipeline flushes without orphaning DMEM responses.

---
 rtl/amber128_mem_stage.sv | 189 ++++++++++++++++++
 tb/tb_amber128_mem_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/amber128_mem_stage.sv
// amber128 memory stage: ALU/trap results retire 1 cycle after acceptance; LD/ST become a DMEM
// valid/ready request and retire 1 cycle after the response. ex_ready_o drops while a memory op is in flight.
package amber128_pkg;
   typedef logic [3:0] trap_cause_t;
   localparam trap_cause_t TRAP_NONE = 4'd0;

   typedef struct packed {
      logic          valid;
      logic [4:0]    rd;
      logic          wb_en;
      logic [127:0]  result;
      logic          mem_req;
      logic          mem_we;
      logic [63:0]   mem_addr;
      logic [127:0]  mem_wdata;
      logic          trap;
      trap_cause_t   trap_cause;
   } amber128_exec_out_s;
endpackage

module amber128_mem_stage
   import amber128_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 128,
   parameter int RD_W   = 5
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               flush_i,
   input  amber128_exec_out_s ex_i,
   output logic               ex_ready_o,
   output logic               dmem_req_valid_o,
   input  logic               dmem_req_ready_i,
   output logic               dmem_req_we_o,
   output logic [ADDR_W-1:0]  dmem_req_addr_o,
   output logic [DATA_W-1:0]  dmem_req_wdata_o,
   input  logic               dmem_rsp_valid_i,
   input  logic [DATA_W-1:0]  dmem_rsp_rdata_i,
   input  logic               dmem_rsp_err_i,
   input  trap_cause_t        dmem_rsp_cause_i,
   output logic               wb_valid_o,
   output logic               wb_en_o,
   output logic [RD_W-1:0]    wb_rd_o,
   output logic [DATA_W-1:0]  wb_data_o,
   output logic               wb_trap_o,
   output trap_cause_t        wb_trap_cause_o
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DRAIN} state_e;

   state_e               state_q, state_d;
   logic                 killed_q, killed_d;
   logic                 req_vld_q, req_vld_d;
   logic                 req_we_q, req_we_d;
   logic [ADDR_W-1:0]    req_addr_q, req_addr_d;
   logic [DATA_W-1:0]    req_wdata_q, req_wdata_d;
   logic [RD_W-1:0]      cap_rd_q, cap_rd_d;
   logic                 cap_wben_q, cap_wben_d;
   logic                 wb_vld_q, wb_vld_d;
   logic                 wb_en_q, wb_en_d;
   logic [RD_W-1:0]      wb_rd_q, wb_rd_d;
   logic [DATA_W-1:0]    wb_data_q, wb_data_d;
   logic                 wb_trap_q, wb_trap_d;
   trap_cause_t          wb_cause_q, wb_cause_d;

   always_comb begin
      state_d     = state_q;
      killed_d    = killed_q;
      req_vld_d   = req_vld_q;
      req_we_d    = req_we_q;
      req_addr_d  = req_addr_q;
      req_wdata_d = req_wdata_q;
      cap_rd_d    = cap_rd_q;
      cap_wben_d  = cap_wben_q;
      wb_vld_d    = 1'b0;
      wb_en_d     = 1'b0;
      wb_rd_d     = '0;
      wb_data_d   = '0;
      wb_trap_d   = 1'b0;
      wb_cause_d  = TRAP_NONE;

      case (state_q)
         S_IDLE: begin
            if (ex_i.valid && !flush_i) begin
               // Trap wins over mem_req so a faulting record never touches DMEM.
               if (ex_i.trap) begin
                  wb_vld_d   = 1'b1;
                  wb_trap_d  = 1'b1;
                  wb_cause_d = ex_i.trap_cause;
                  wb_rd_d    = ex_i.rd;
               end else if (!ex_i.mem_req) begin
                  wb_vld_d  = 1'b1;
                  wb_en_d   = ex_i.wb_en;
                  wb_rd_d   = ex_i.rd;
                  wb_data_d = ex_i.result;
               end else begin
                  state_d     = S_REQ;
                  killed_d    = 1'b0;
                  req_vld_d   = 1'b1;
                  req_we_d    = ex_i.mem_we;
                  req_addr_d  = ex_i.mem_addr;
                  req_wdata_d = ex_i.mem_wdata;
                  cap_rd_d    = ex_i.rd;
                  cap_wben_d  = ex_i.wb_en;
               end
            end
         end
         S_REQ: begin
            // A flushed request must still complete its handshake; only its result is dropped.
            if (flush_i) killed_d = 1'b1;
            if (dmem_req_ready_i) begin
               req_vld_d = 1'b0;
               killed_d  = 1'b0;
               state_d   = (killed_q || flush_i) ? S_DRAIN : S_WAIT;
            end
         end
         S_WAIT: begin
            if (dmem_rsp_valid_i) begin
               state_d = S_IDLE;
               if (!flush_i) begin
                  wb_vld_d = 1'b1;
                  wb_rd_d  = cap_rd_q;
                  if (dmem_rsp_err_i) begin
                     wb_trap_d  = 1'b1;
                     wb_cause_d = dmem_rsp_cause_i;
                  end else if (!req_we_q) begin
                     wb_en_d   = cap_wben_q;
                     wb_data_d = dmem_rsp_rdata_i;
                  end
               end
            end else if (flush_i) begin
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (dmem_rsp_valid_i) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         killed_q    <= 1'b0;
         req_vld_q   <= 1'b0;
         req_we_q    <= 1'b0;
         req_addr_q  <= '0;
         req_wdata_q <= '0;
         cap_rd_q    <= '0;
         cap_wben_q  <= 1'b0;
         wb_vld_q    <= 1'b0;
         wb_en_q     <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         wb_trap_q   <= 1'b0;
         wb_cause_q  <= TRAP_NONE;
      end else begin
         state_q     <= state_d;
         killed_q    <= killed_d;
         req_vld_q   <= req_vld_d;
         req_we_q    <= req_we_d;
         req_addr_q  <= req_addr_d;
         req_wdata_q <= req_wdata_d;
         cap_rd_q    <= cap_rd_d;
         cap_wben_q  <= cap_wben_d;
         wb_vld_q    <= wb_vld_d;
         wb_en_q     <= wb_en_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
         wb_trap_q   <= wb_trap_d;
         wb_cause_q  <= wb_cause_d;
      end
   end

   assign ex_ready_o       = (state_q == S_IDLE);
   assign dmem_req_valid_o = req_vld_q;
   assign dmem_req_we_o    = req_we_q;
   assign dmem_req_addr_o  = req_addr_q;
   assign dmem_req_wdata_o = req_wdata_q;
   assign wb_valid_o       = wb_vld_q;
   assign wb_en_o          = wb_en_q;
   assign wb_rd_o          = wb_rd_q;
   assign wb_data_o        = wb_data_q;
   assign wb_trap_o        = wb_trap_q;
   assign wb_trap_cause_o  = wb_cause_q;

endmodule

// File: tb/tb_amber128_mem_stage.sv
// Bench for amber128_mem_stage: transaction-level model (one outstanding op, killed or not),
// directed scenarios plus randomized traffic against a bench-side DMEM.
module tb_amber128_mem_stage;
   import amber128_pkg::*;

   logic               clk_i = 1'b0;
   logic               rst_ni;
   logic               flush_i;
   amber128_exec_out_s ex_i;
   logic               ex_ready_o;
   logic               dmem_req_valid_o;
   logic               dmem_req_ready_i;
   logic               dmem_req_we_o;
   logic [63:0]        dmem_req_addr_o;
   logic [127:0]       dmem_req_wdata_o;
   logic               dmem_rsp_valid_i;
   logic [127:0]       dmem_rsp_rdata_i;
   logic               dmem_rsp_err_i;
   trap_cause_t        dmem_rsp_cause_i;
   logic               wb_valid_o;
   logic               wb_en_o;
   logic [4:0]         wb_rd_o;
   logic [127:0]       wb_data_o;
   logic               wb_trap_o;
   trap_cause_t        wb_trap_cause_o;

   amber128_mem_stage dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .ex_i(ex_i), .ex_ready_o(ex_ready_o),
      .dmem_req_valid_o(dmem_req_valid_o), .dmem_req_ready_i(dmem_req_ready_i),
      .dmem_req_we_o(dmem_req_we_o), .dmem_req_addr_o(dmem_req_addr_o),
      .dmem_req_wdata_o(dmem_req_wdata_o), .dmem_rsp_valid_i(dmem_rsp_valid_i),
      .dmem_rsp_rdata_i(dmem_rsp_rdata_i), .dmem_rsp_err_i(dmem_rsp_err_i),
      .dmem_rsp_cause_i(dmem_rsp_cause_i), .wb_valid_o(wb_valid_o), .wb_en_o(wb_en_o),
      .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o), .wb_trap_o(wb_trap_o),
      .wb_trap_cause_o(wb_trap_cause_o)
   );

   always #5 clk_i = ~clk_i;

   int n_chk = 0;
   int n_fail = 0;

   // Model: at most one memory op outstanding; 'accepted' once the DMEM handshake happened.
   logic         busy, accepted, killed;
   logic         p_we, p_wben;
   logic [63:0]  p_addr;
   logic [127:0] p_wdata;
   logic [4:0]   p_rd;
   logic         e_vld, e_en, e_trap;
   logic [4:0]   e_rd;
   logic [127:0] e_data;
   trap_cause_t  e_cause;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      busy = 0; accepted = 0; killed = 0;
      p_we = 0; p_wben = 0; p_addr = '0; p_wdata = '0; p_rd = '0;
      e_vld = 0; e_en = 0; e_trap = 0; e_rd = '0; e_data = '0; e_cause = TRAP_NONE;
   endtask

   // Applies the currently driven inputs as one clock edge of the model.
   task automatic model_edge();
      logic ack_now;
      e_vld = 0; e_en = 0; e_trap = 0; e_rd = '0; e_data = '0; e_cause = TRAP_NONE;
      if (!busy) begin
         if (ex_i.valid && !flush_i) begin
            if (ex_i.trap) begin
               e_vld = 1; e_trap = 1; e_cause = ex_i.trap_cause;
            end else if (!ex_i.mem_req) begin
               e_vld = 1; e_en = ex_i.wb_en; e_rd = ex_i.rd; e_data = ex_i.result;
            end else begin
               busy = 1; accepted = 0; killed = 0;
               p_we = ex_i.mem_we; p_addr = ex_i.mem_addr; p_wdata = ex_i.mem_wdata;
               p_rd = ex_i.rd; p_wben = ex_i.wb_en;
            end
         end
      end else if (!accepted) begin
         ack_now = dmem_req_ready_i;
         if (flush_i) killed = 1;
         if (ack_now) accepted = 1;
      end else if (dmem_rsp_valid_i) begin
         busy = 0;
         if (!killed && !flush_i) begin
            e_vld = 1;
            if (dmem_rsp_err_i) begin
               e_trap = 1; e_cause = dmem_rsp_cause_i;
            end else if (!p_we) begin
               e_en = p_wben; e_rd = p_rd; e_data = dmem_rsp_rdata_i;
            end
         end
      end else if (flush_i) begin
         killed = 1;
      end
   endtask

   task automatic compare_all();
      chk("ex_ready", 128'(ex_ready_o), 128'(!busy));
      chk("req_valid", 128'(dmem_req_valid_o), 128'(busy && !accepted));
      if (busy && !accepted) begin
         chk("req_we", 128'(dmem_req_we_o), 128'(p_we));
         chk("req_addr", 128'(dmem_req_addr_o), 128'(p_addr));
         chk("req_wdata", dmem_req_wdata_o, p_wdata);
      end
      chk("wb_valid", 128'(wb_valid_o), 128'(e_vld));
      chk("wb_en", 128'(wb_en_o), 128'(e_en));
      chk("wb_trap", 128'(wb_trap_o), 128'(e_trap));
      chk("wb_cause", 128'(wb_trap_cause_o), 128'(e_cause));
      if (e_vld && e_en) chk("wb_rd", 128'(wb_rd_o), 128'(e_rd));
      if (e_vld && !e_trap) chk("wb_data", wb_data_o, e_data);
   endtask

   // Called at a falling edge: drive, run model, cross the rising edge, compare at next falling edge.
   task automatic step(input amber128_exec_out_s e, input logic fl, input logic rdy, input logic rv);
      ex_i = e; flush_i = fl; dmem_req_ready_i = rdy; dmem_rsp_valid_i = rv;
      model_edge();
      @(posedge clk_i);
      @(negedge clk_i);
      compare_all();
   endtask

   function automatic amber128_exec_out_s mk(input logic v, input logic [4:0] rd, input logic wben,
         input logic [127:0] res, input logic mreq, input logic we, input logic [63:0] addr,
         input logic [127:0] wdata, input logic trap, input trap_cause_t cause);
      amber128_exec_out_s r;
      r.valid = v; r.rd = rd; r.wb_en = wben; r.result = res; r.mem_req = mreq; r.mem_we = we;
      r.mem_addr = addr; r.mem_wdata = wdata; r.trap = trap; r.trap_cause = cause;
      return r;
   endfunction

   function automatic amber128_exec_out_s alu(input logic [4:0] rd, input logic [127:0] res);
      return mk(1, rd, 1, res, 0, 0, '0, '0, 0, TRAP_NONE);
   endfunction
   function automatic amber128_exec_out_s ld(input logic [4:0] rd, input logic [63:0] addr);
      return mk(1, rd, 1, '0, 1, 0, addr, '0, 0, TRAP_NONE);
   endfunction
   function automatic amber128_exec_out_s idle_rec();
      return mk(0, '0, 0, '0, 0, 0, '0, '0, 0, TRAP_NONE);
   endfunction

   function automatic amber128_exec_out_s rand_ex();
      amber128_exec_out_s r;
      r.valid      = ($urandom_range(0, 3) != 0);
      r.rd         = 5'($urandom);
      r.wb_en      = 1'($urandom);
      r.result     = {$urandom(), $urandom(), $urandom(), $urandom()};
      r.mem_req    = 1'($urandom);
      r.mem_we     = 1'($urandom);
      r.mem_addr   = {$urandom(), $urandom()};
      r.mem_wdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
      r.trap       = ($urandom_range(0, 7) == 0);
      r.trap_cause = r.trap ? 4'($urandom_range(1, 15)) : TRAP_NONE;
      return r;
   endfunction

   initial begin
      amber128_exec_out_s cur;
      logic rv, rdy, fl, was_acc;
      int rsp_wait;
      rst_ni = 0; flush_i = 0; ex_i = idle_rec(); dmem_req_ready_i = 0; dmem_rsp_valid_i = 0;
      dmem_rsp_rdata_i = '0; dmem_rsp_err_i = 0; dmem_rsp_cause_i = TRAP_NONE;
      model_reset();
      #1;
      chk("rst_ready", 128'(ex_ready_o), 128'(1));
      chk("rst_req_valid", 128'(dmem_req_valid_o), 128'(0));
      chk("rst_wb_cause", 128'(wb_trap_cause_o), 128'(TRAP_NONE));
      compare_all();
      @(negedge clk_i); @(negedge clk_i);
      rst_ni = 1;

      // Back-to-back ALU ops
      step(alu(1, 128'h11), 0, 0, 0);
      chk("alu1_lit", {wb_valid_o, wb_rd_o, wb_data_o[7:0]}, {1'b1, 5'd1, 8'h11});
      step(alu(2, 128'h22), 0, 0, 0);
      chk("alu2_lit", {wb_valid_o, wb_rd_o, wb_data_o[7:0]}, {1'b1, 5'd2, 8'h22});
      step(alu(3, 128'h33), 0, 0, 0);
      chk("alu3_lit", {wb_valid_o, wb_rd_o, wb_data_o[7:0], ex_ready_o}, {1'b1, 5'd3, 8'h33, 1'b1});
      step(idle_rec(), 0, 0, 0);

      // Load with 2-cycle ready stall, response 3 cycles after acceptance
      step(ld(4, 64'h40), 0, 0, 0);
      chk("ld_req_addr_lit", 128'(dmem_req_addr_o), 128'h40);
      step(idle_rec(), 0, 0, 0);
      step(idle_rec(), 0, 0, 0);
      step(idle_rec(), 0, 1, 0);
      step(idle_rec(), 0, 0, 0);
      step(idle_rec(), 0, 0, 0);
      dmem_rsp_rdata_i = 128'hDEAD_BEEF;
      step(idle_rec(), 0, 0, 1);
      chk("ld_data_lit", {wb_valid_o, wb_en_o, wb_data_o}, {1'b1, 1'b1, 128'hDEAD_BEEF});

      // Store of all-ones
      step(mk(1, 5, 1, '0, 1, 1, 64'h80, '1, 0, TRAP_NONE), 0, 0, 0);
      chk("st_we_lit", 128'(dmem_req_we_o), 128'(1));
      step(idle_rec(), 0, 1, 0);
      step(idle_rec(), 0, 0, 1);
      chk("st_wb_lit", {wb_valid_o, wb_en_o}, 2'b10);

      // Load faulting at DMEM, then trap record that also requests memory
      step(ld(6, 64'h41), 0, 0, 0);
      step(idle_rec(), 0, 1, 0);
      dmem_rsp_err_i = 1; dmem_rsp_cause_i = 4'd5;
      step(idle_rec(), 0, 0, 1);
      chk("err_lit", {wb_valid_o, wb_en_o, wb_trap_o, wb_trap_cause_o}, {3'b101, 4'd5});
      dmem_rsp_err_i = 0; dmem_rsp_cause_i = TRAP_NONE;
      step(mk(1, 7, 1, '0, 1, 0, 64'h50, '0, 1, 4'd3), 0, 1, 0);
      chk("trapmem_lit", {dmem_req_valid_o, wb_trap_o, wb_trap_cause_o}, {2'b01, 4'd3});

      // Flush in REQ with ready low, in WAIT, and together with the response
      step(ld(8, 64'h60), 0, 0, 0);
      step(idle_rec(), 1, 0, 0);
      step(idle_rec(), 0, 1, 0);
      step(idle_rec(), 0, 0, 1);
      step(alu(9, 128'h99), 0, 0, 0);
      chk("after_flush_req_lit", {wb_valid_o, wb_rd_o}, {1'b1, 5'd9});
      step(ld(10, 64'h70), 0, 0, 0);
      step(idle_rec(), 0, 1, 0);
      step(idle_rec(), 1, 0, 0);
      step(idle_rec(), 0, 0, 1);
      step(alu(11, 128'hAA), 0, 0, 0);
      step(ld(12, 64'h78), 0, 0, 0);
      step(idle_rec(), 0, 1, 0);
      step(idle_rec(), 1, 0, 1);
      chk("flush_rsp_lit", 128'(wb_valid_o), 128'(0));
      step(alu(13, 128'hBB), 0, 0, 0);

      // Reset asserted while waiting for a response
      step(ld(14, 64'h88), 0, 0, 0);
      step(idle_rec(), 0, 1, 0);
      ex_i = idle_rec(); dmem_req_ready_i = 0;
      rst_ni = 0;
      #1;
      model_reset();
      chk("midrst_lit", {ex_ready_o, dmem_req_valid_o, wb_valid_o}, 3'b100);
      compare_all();
      @(negedge clk_i);
      rst_ni = 1;
      step(ld(15, 64'h90), 0, 0, 0);
      step(idle_rec(), 0, 1, 0);
      dmem_rsp_rdata_i = 128'h1234;
      step(idle_rec(), 0, 0, 1);
      chk("post_rst_ld_lit", {wb_valid_o, wb_rd_o, wb_data_o}, {1'b1, 5'd15, 128'h1234});

      // Randomized traffic with a bench-side DMEM
      cur = rand_ex();
      rsp_wait = 0;
      for (int i = 0; i < 4000; i++) begin
         if (!busy) cur = rand_ex();
         rv = 0;
         if (busy && accepted) begin
            if (rsp_wait == 0) rv = 1;
            else rsp_wait--;
         end
         rdy = ($urandom_range(0, 2) != 0);
         fl  = ($urandom_range(0, 9) == 0);
         dmem_rsp_rdata_i = {$urandom(), $urandom(), $urandom(), $urandom()};
         dmem_rsp_err_i   = ($urandom_range(0, 4) == 0);
         dmem_rsp_cause_i = 4'($urandom_range(1, 15));
         was_acc = busy && accepted;
         step(cur, fl, rdy, rv);
         if (busy && accepted && !was_acc) rsp_wait = $urandom_range(0, 3);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
